cra_diag_seq: RTL and testbench

Diagnostic sequencer for the CRA micro-address path. Decodes diagnostic function strobes from the console/EBUS side and loads the 11-bit diagnostic CRAM address. Sequences CRA through diag dispatch, force-to-1777, N-cycle single-step and CRADR readback onto EBUS. Sits between the EBUS diagnostic decoder and cra; cra selects diagAdr when diagDispEn is high.

---
 rtl/cra_pkg.sv | 34 +++
 rtl/cra_diag_cnt.sv | 43 ++++
 rtl/cra_diag_seq.sv | 225 ++++++++++++++++++++++
 tb/tb_cra_diag_seq.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cra_pkg.sv
// ----------------------------------------------------------------------------
// cra_pkg
// Shared definitions for the CRA diagnostic path: the diagnostic function
// codes that arrive from the console/EBUS decoder and the state encoding
// used by the diagnostic sequencer.
// No ports (package).
// ----------------------------------------------------------------------------
package cra_pkg;

    // Diagnostic function codes (octal, as the console documents them)
    localparam logic [8:0] DIAG_LDADR_LO = 9'o051;
    localparam logic [8:0] DIAG_LDADR_HI = 9'o052;
    localparam logic [8:0] DIAG_DISP     = 9'o053;
    localparam logic [8:0] DIAG_STEP     = 9'o054;
    localparam logic [8:0] DIAG_READ     = 9'o055;
    localparam logic [8:0] DIAG_FORCE    = 9'o056;

    // Sequencer states
    typedef enum logic [2:0] {
        IDLE,
        DISP,
        STEP,
        RDREQ,
        RDDRV,
        FORCE
    } diagState_e;

    // True for any function code this block recognises; everything else is
    // silently ignored and never raises diagErr.
    function automatic logic isDiagFunc(input logic [8:0] code);
        return (code >= DIAG_LDADR_LO) && (code <= DIAG_FORCE);
    endfunction

endpackage

// File: rtl/cra_diag_cnt.sv
// ----------------------------------------------------------------------------
// cra_diag_cnt
// Loadable down-counter with a zero flag. Used by the diagnostic sequencer
// both for the single-step cycle count and for the EBUS drive hold count.
// Decrement saturates at zero so the count can never wrap.
//
// Ports:
//   clk        system clock
//   resetN     asynchronous active-low reset (count -> 0)
//   i_load     load i_loadVal this edge (takes priority over i_dec)
//   i_loadVal  value to load
//   i_dec      decrement by one this edge (ignored when already zero)
//   o_count    current count
//   o_zero     count is zero
// ----------------------------------------------------------------------------
module cra_diag_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         resetN,
    input  logic         i_load,
    input  logic [W-1:0] i_loadVal,
    input  logic         i_dec,
    output logic [W-1:0] o_count,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_loadVal;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == '0);

endmodule

// File: rtl/cra_diag_seq.sv
// ----------------------------------------------------------------------------
// cra_diag_seq
// Diagnostic sequencer for the CRA micro-address path. Decodes diagnostic
// function strobes from the console/EBUS side, loads the 11-bit diagnostic
// CRAM address and sequences CRA through diag dispatch, force-to-1777,
// N-cycle single-step and CRADR readback onto EBUS. Every output comes
// straight from a flop so nothing decoded from state can glitch onto EBUS.
//
// Ports:
//   clk          system clock
//   resetN       asynchronous active-low reset
//   diagStrobe   one-cycle valid for diagFunc
//   diagFunc     diagnostic function code (octal 051..056 used)
//   ebusIn       EBUS data (bit 0 is MSB)
//   CRADR        current CRAM address from cra
//   ebusGrant    EBUS arbiter grant
//   diagAdr      diagnostic CRAM address
//   diagDispEn   cra takes dispatch from diagAdr this cycle
//   force1777    force CRADR to 1777
//   runEnable    microcode clock enable for stepping
//   ebusReq      EBUS request
//   drivingEBUS  block drives EBUS
//   ebusOut      EBUS data when driving, else 0
//   busy         sequencer not IDLE
//   diagErr      one-cycle pulse: function rejected because busy
// ----------------------------------------------------------------------------
module cra_diag_seq
    import cra_pkg::*;
#(
    parameter int EBUS_HOLD = 3,
    parameter int STEP_W    = 8
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        diagStrobe,
    input  logic [0:8]  diagFunc,
    input  logic [0:35] ebusIn,
    input  logic [11:0] CRADR,
    input  logic        ebusGrant,
    output logic [0:10] diagAdr,
    output logic        diagDispEn,
    output logic        force1777,
    output logic        runEnable,
    output logic        ebusReq,
    output logic        drivingEBUS,
    output logic [0:35] ebusOut,
    output logic        busy,
    output logic        diagErr
);

    localparam int HOLD_W = $clog2(EBUS_HOLD + 1);

    diagState_e r_state, w_state;

    logic [0:10] r_diagAdr, w_diagAdr;
    logic        r_dispEn,  w_dispEn;
    logic        r_force,   w_force;
    logic        r_run,     w_run;
    logic        r_req,     w_req;
    logic        r_drive,   w_drive;
    logic [0:35] r_ebusOut, w_ebusOut;
    logic        r_busy,    w_busy;
    logic        r_err,     w_err;

    logic              w_stepLoad, w_stepDec, w_stepZero;
    logic [STEP_W-1:0] w_stepN, w_stepCnt;
    logic              w_holdLoad, w_holdDec, w_holdZero;
    logic [HOLD_W-1:0] w_holdCnt;
    logic              w_stepLast, w_holdLast;
    logic              w_unused;

    // Step count is the low STEP_W bits of the EBUS word
    assign w_stepN  = ebusIn[36-STEP_W:35];
    assign w_unused = ^ebusIn;

    cra_diag_cnt #(.W(STEP_W)) u_stepCnt (
        .clk       (clk),
        .resetN    (resetN),
        .i_load    (w_stepLoad),
        .i_loadVal (w_stepN),
        .i_dec     (w_stepDec),
        .o_count   (w_stepCnt),
        .o_zero    (w_stepZero)
    );

    cra_diag_cnt #(.W(HOLD_W)) u_holdCnt (
        .clk       (clk),
        .resetN    (resetN),
        .i_load    (w_holdLoad),
        .i_loadVal (HOLD_W'(EBUS_HOLD)),
        .i_dec     (w_holdDec),
        .o_count   (w_holdCnt),
        .o_zero    (w_holdZero)
    );

    // The counter holds the number of cycles still to run including the
    // current one, so a count of one (or zero for n=0) ends the phase.
    assign w_stepLast = w_stepZero || (w_stepCnt == STEP_W'(1));
    assign w_holdLast = w_holdZero || (w_holdCnt == HOLD_W'(1));

    // Next-state and next-output logic. Outputs are computed for the cycle
    // that follows the edge and then registered below.
    always_comb begin
        w_state    = r_state;
        w_diagAdr  = r_diagAdr;
        w_dispEn   = 1'b0;
        w_force    = 1'b0;
        w_run      = 1'b0;
        w_req      = 1'b0;
        w_drive    = 1'b0;
        w_ebusOut  = '0;
        w_err      = 1'b0;
        w_stepLoad = 1'b0;
        w_stepDec  = 1'b0;
        w_holdLoad = 1'b0;
        w_holdDec  = 1'b0;

        case (r_state)
            IDLE: begin
                if (diagStrobe) begin
                    case (diagFunc)
                        DIAG_LDADR_LO: w_diagAdr[5:10] = ebusIn[0:5];
                        DIAG_LDADR_HI: w_diagAdr[0:4]  = ebusIn[1:5];
                        DIAG_DISP: begin
                            w_state  = DISP;
                            w_dispEn = 1'b1;
                        end
                        DIAG_STEP: begin
                            w_state    = STEP;
                            w_stepLoad = 1'b1;
                            w_run      = (w_stepN != '0);
                        end
                        DIAG_READ: begin
                            w_state = RDREQ;
                            w_req   = 1'b1;
                        end
                        DIAG_FORCE: begin
                            w_state = FORCE;
                            w_force = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            DISP, FORCE: begin
                w_state = IDLE;
            end
            STEP: begin
                if (w_stepLast) begin
                    w_state = IDLE;
                end else begin
                    w_stepDec = 1'b1;
                    w_run     = 1'b1;
                end
            end
            RDREQ: begin
                w_req = 1'b1;
                if (ebusGrant) begin
                    w_state    = RDDRV;
                    w_holdLoad = 1'b1;
                    w_drive    = 1'b1;
                    w_ebusOut  = {24'b0, CRADR};
                end
            end
            RDDRV: begin
                if (w_holdLast) begin
                    w_state = IDLE;
                end else begin
                    w_holdDec = 1'b1;
                    w_req     = 1'b1;
                    w_drive   = 1'b1;
                    w_ebusOut = r_ebusOut;
                end
            end
            default: begin
                w_state = IDLE;
            end
        endcase

        // A recognised function arriving mid-operation is dropped and flagged
        if (diagStrobe && isDiagFunc(diagFunc) && (r_state != IDLE)) begin
            w_err = 1'b1;
        end

        w_busy = (w_state != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state   <= IDLE;
            r_diagAdr <= '0;
            r_dispEn  <= 1'b0;
            r_force   <= 1'b0;
            r_run     <= 1'b0;
            r_req     <= 1'b0;
            r_drive   <= 1'b0;
            r_ebusOut <= '0;
            r_busy    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_diagAdr <= w_diagAdr;
            r_dispEn  <= w_dispEn;
            r_force   <= w_force;
            r_run     <= w_run;
            r_req     <= w_req;
            r_drive   <= w_drive;
            r_ebusOut <= w_ebusOut;
            r_busy    <= w_busy;
            r_err     <= w_err;
        end
    end

    assign diagAdr     = r_diagAdr;
    assign diagDispEn  = r_dispEn;
    assign force1777   = r_force;
    assign runEnable   = r_run;
    assign ebusReq     = r_req;
    assign drivingEBUS = r_drive;
    assign ebusOut     = r_ebusOut;
    assign busy        = r_busy;
    assign diagErr     = r_err;

endmodule

// File: tb/tb_cra_diag_seq.sv
// ----------------------------------------------------------------------------
// tb_cra_diag_seq
// Self-checking bench for cra_diag_seq. A behavioural model keeps a queue of
// planned per-cycle output slots (one entry per future cycle) plus a flag for
// an outstanding EBUS read; every cycle the DUT outputs are compared against
// the slot for that cycle.
// ----------------------------------------------------------------------------
module tb_cra_diag_seq;

    localparam int EBUS_HOLD = 3;
    localparam int STEP_W    = 8;

    logic        clk;
    logic        resetN;
    logic        diagStrobe;
    logic [0:8]  diagFunc;
    logic [0:35] ebusIn;
    logic [11:0] CRADR;
    logic        ebusGrant;
    logic [0:10] diagAdr;
    logic        diagDispEn;
    logic        force1777;
    logic        runEnable;
    logic        ebusReq;
    logic        drivingEBUS;
    logic [0:35] ebusOut;
    logic        busy;
    logic        diagErr;

    cra_diag_seq #(.EBUS_HOLD(EBUS_HOLD), .STEP_W(STEP_W)) dut (
        .clk         (clk),
        .resetN      (resetN),
        .diagStrobe  (diagStrobe),
        .diagFunc    (diagFunc),
        .ebusIn      (ebusIn),
        .CRADR       (CRADR),
        .ebusGrant   (ebusGrant),
        .diagAdr     (diagAdr),
        .diagDispEn  (diagDispEn),
        .force1777   (force1777),
        .runEnable   (runEnable),
        .ebusReq     (ebusReq),
        .drivingEBUS (drivingEBUS),
        .ebusOut     (ebusOut),
        .busy        (busy),
        .diagErr     (diagErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          busy;
        bit          disp;
        bit          run;
        bit          frc;
        bit          req;
        bit          drv;
        logic [35:0] word;
    } slot_t;

    slot_t       plan[$];
    slot_t       cur;
    bit          waitGrant;
    bit          expErr;
    logic [10:0] expAdr;
    int          totalChecks = 0;
    int          badChecks   = 0;

    function automatic slot_t mkSlot(bit b, bit d, bit r, bit f, bit q, bit v,
                                     logic [35:0] w);
        slot_t s;
        s.busy = b; s.disp = d; s.run = r; s.frc = f;
        s.req = q; s.drv = v; s.word = w;
        return s;
    endfunction

    task automatic modelReset();
        plan.delete();
        cur       = mkSlot(0, 0, 0, 0, 0, 0, 36'd0);
        waitGrant = 0;
        expErr    = 0;
        expAdr    = 11'd0;
    endtask

    // Advance the model by one clock edge using the inputs sampled there
    task automatic modelEdge();
        bit          wasBusy;
        bit          wasWaiting;
        int          n;
        logic [35:0] bus;
        if (!resetN) begin
            modelReset();
            return;
        end
        bus        = ebusIn;
        wasBusy    = cur.busy;
        wasWaiting = waitGrant;
        expErr     = 0;
        if (diagStrobe && diagFunc >= 9'o051 && diagFunc <= 9'o056) begin
            if (wasBusy) begin
                expErr = 1;
            end else begin
                case (diagFunc)
                    9'o051: expAdr = (expAdr & ~11'o77) | 11'((bus >> 30) & 36'o77);
                    9'o052: expAdr = (expAdr & 11'o77) | 11'(((bus >> 30) & 36'o37) << 6);
                    9'o053: plan.push_back(mkSlot(1, 1, 0, 0, 0, 0, 36'd0));
                    9'o054: begin
                        n = int'(bus % (36'd1 << STEP_W));
                        if (n == 0) plan.push_back(mkSlot(1, 0, 0, 0, 0, 0, 36'd0));
                        else repeat (n) plan.push_back(mkSlot(1, 0, 1, 0, 0, 0, 36'd0));
                    end
                    9'o055: waitGrant = 1;
                    9'o056: plan.push_back(mkSlot(1, 0, 0, 1, 0, 0, 36'd0));
                    default: ;
                endcase
            end
        end
        if (wasWaiting && ebusGrant) begin
            waitGrant = 0;
            repeat (EBUS_HOLD) plan.push_back(mkSlot(1, 0, 0, 0, 1, 1, 36'(CRADR)));
        end
        if (plan.size() > 0) cur = plan.pop_front();
        else if (waitGrant) cur = mkSlot(1, 0, 0, 0, 1, 0, 36'd0);
        else cur = mkSlot(0, 0, 0, 0, 0, 0, 36'd0);
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic checkAll();
        checkOutput("diagAdr", 64'(diagAdr), 64'(expAdr));
        checkOutput("diagDispEn", 64'(diagDispEn), 64'(cur.disp));
        checkOutput("force1777", 64'(force1777), 64'(cur.frc));
        checkOutput("runEnable", 64'(runEnable), 64'(cur.run));
        checkOutput("ebusReq", 64'(ebusReq), 64'(cur.req));
        checkOutput("drivingEBUS", 64'(drivingEBUS), 64'(cur.drv));
        checkOutput("ebusOut", 64'(ebusOut), 64'(cur.drv ? cur.word : 36'd0));
        checkOutput("busy", 64'(busy), 64'(cur.busy));
        checkOutput("diagErr", 64'(diagErr), 64'(expErr));
    endtask

    // Drive one cycle of inputs, let the edge happen, then compare
    task automatic applyStimulus(input bit strobe, input logic [8:0] func,
                                 input logic [35:0] bus, input bit grant);
        diagStrobe = strobe;
        diagFunc   = func;
        ebusIn     = bus;
        ebusGrant  = grant;
        @(posedge clk);
        modelEdge();
        #1;
        checkAll();
    endtask

    task automatic idleCycles(input int n);
        repeat (n) applyStimulus(0, 9'o0, 36'd0, 0);
    endtask

    initial begin
        int          runCount;
        int          r;
        bit          s;
        logic [8:0]  f;
        logic [35:0] b;

        resetN     = 1'b0;
        diagStrobe = 1'b0;
        diagFunc   = '0;
        ebusIn     = '0;
        CRADR      = '0;
        ebusGrant  = 1'b0;
        modelReset();
        #12;
        checkAll();
        resetN = 1'b1;

        // Address load, low then high half
        applyStimulus(1, 9'o051, 36'o52 << 30, 0);
        applyStimulus(1, 9'o052, 36'o25 << 30, 0);
        idleCycles(1);
        checkOutput("adr2552", 64'(diagAdr), 64'(11'o2552));

        // Dispatch and force
        applyStimulus(1, 9'o053, 36'd0, 0);
        idleCycles(2);
        applyStimulus(1, 9'o056, 36'd0, 0);
        idleCycles(2);

        // Step 5, step 0, unknown code
        applyStimulus(1, 9'o054, 36'd5, 0);
        idleCycles(7);
        applyStimulus(1, 9'o054, 36'o777777777400, 0);
        idleCycles(2);
        applyStimulus(1, 9'o057, 36'd7, 0);
        idleCycles(1);

        // Readback with grant held off four cycles
        CRADR = 12'o1234;
        applyStimulus(1, 9'o055, 36'd0, 0);
        repeat (4) applyStimulus(0, 9'o0, 36'd0, 0);
        applyStimulus(0, 9'o0, 36'd0, 1);
        checkOutput("rdWord", 64'(ebusOut), 64'(12'o1234));
        CRADR = 12'o7777;
        idleCycles(5);

        // Rejected load during a 10-cycle step
        runCount = 0;
        applyStimulus(1, 9'o054, 36'd10, 0);
        runCount += int'(runEnable);
        applyStimulus(0, 9'o0, 36'd0, 0);
        runCount += int'(runEnable);
        applyStimulus(1, 9'o051, 36'o77 << 30, 0);
        runCount += int'(runEnable);
        checkOutput("errPulse", 64'(diagErr), 64'd1);
        repeat (12) begin
            applyStimulus(0, 9'o0, 36'd0, 0);
            runCount += int'(runEnable);
        end
        checkOutput("step10Total", 64'(runCount), 64'd10);
        checkOutput("adrKept", 64'(diagAdr), 64'(11'o2552));

        // Largest step count
        applyStimulus(1, 9'o054, 36'd255, 0);
        idleCycles(258);

        // Reset in the middle of driving EBUS
        CRADR = 12'o4321;
        applyStimulus(1, 9'o055, 36'd0, 0);
        applyStimulus(0, 9'o0, 36'd0, 1);
        applyStimulus(0, 9'o0, 36'd0, 0);
        checkOutput("drvPreRst", 64'(drivingEBUS), 64'd1);
        #2 resetN = 1'b0;
        #1;
        checkOutput("rstDrv", 64'(drivingEBUS), 64'd0);
        checkOutput("rstOut", 64'(ebusOut), 64'd0);
        checkOutput("rstReq", 64'(ebusReq), 64'd0);
        modelReset();
        idleCycles(2);
        resetN = 1'b1;
        idleCycles(2);
        checkOutput("rstAdr", 64'(diagAdr), 64'd0);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            CRADR = 12'($urandom);
            s = ($urandom_range(0, 2) == 0);
            r = $urandom_range(0, 9);
            f = (r < 8) ? 9'(9'o050 + r) : ((r == 8) ? 9'($urandom) : 9'o055);
            b = {4'($urandom), 32'($urandom)};
            if (f == 9'o054 && $urandom_range(0, 7) != 0) b = (b & ~36'hFF) | 36'($urandom_range(0, 12));
            applyStimulus(s, f, b, ($urandom_range(0, 3) == 0));
        end
        idleCycles(20);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
